// File: rtl/ge_p1p1_to_p3_if.sv
// Handshake bundle for ge_p1p1_to_p3: input point, output point,
// and the shared fe_mul start/done interface.
interface ge_p1p1_to_p3_if #(
    parameter int FE_W = 320
);
    logic            valid;
    logic [FE_W-1:0] p_x;
    logic [FE_W-1:0] p_y;
    logic [FE_W-1:0] p_z;
    logic [FE_W-1:0] p_t;
    logic [FE_W-1:0] r_x;
    logic [FE_W-1:0] r_y;
    logic [FE_W-1:0] r_z;
    logic [FE_W-1:0] r_t;
    logic            done;
    logic            busy;
    logic [FE_W-1:0] mul_a;
    logic [FE_W-1:0] mul_b;
    logic            mul_start;
    logic            mul_done;
    logic [FE_W-1:0] mul_out;

    modport slave (
        input  valid, p_x, p_y, p_z, p_t,
        input  mul_done, mul_out,
        output r_x, r_y, r_z, r_t,
        output done, busy,
        output mul_a, mul_b, mul_start
    );

    modport master (
        output valid, p_x, p_y, p_z, p_t,
        output mul_done, mul_out,
        input  r_x, r_y, r_z, r_t,
        input  done, busy,
        input  mul_a, mul_b, mul_start
    );
endinterface

// File: rtl/ge_p1p1_to_p3.sv
// P1P1 -> P3 conversion: X3=X*T, Y3=Y*Z, Z3=Z*T, T3=X*Y via one shared
// fe_mul. Ports: clk, rst (sync, active-low), bus (slave modport).
module ge_p1p1_to_p3 #(
    parameter int FE_W = 320
) (
    input  logic               clk,
    input  logic               rst,
    ge_p1p1_to_p3_if.slave     bus
);
    typedef enum logic [3:0] {
        IDLE, S_XT, W_XT, S_YZ, W_YZ,
        S_ZT, W_ZT, S_XY, W_XY, FIN
    } state_t;

    state_t state_q, state_d;

    logic [FE_W-1:0] ox_q, ox_d;
    logic [FE_W-1:0] oy_q, oy_d;
    logic [FE_W-1:0] oz_q, oz_d;
    logic [FE_W-1:0] ot_q, ot_d;
    logic [FE_W-1:0] rx_q, rx_d;
    logic [FE_W-1:0] ry_q, ry_d;
    logic [FE_W-1:0] rz_q, rz_d;
    logic [FE_W-1:0] rt_q, rt_d;
    logic [FE_W-1:0] a_q, a_d;
    logic [FE_W-1:0] b_q, b_d;
    logic            start;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ox_q    <= '0;
            oy_q    <= '0;
            oz_q    <= '0;
            ot_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            rz_q    <= '0;
            rt_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            oz_q    <= oz_d;
            ot_q    <= ot_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            rz_q    <= rz_d;
            rt_q    <= rt_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Operand registers for the next multiply are loaded one state
    // early, so mul_a/mul_b are already stable in each S_* cycle.
    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        oz_d    = oz_q;
        ot_d    = ot_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        rz_d    = rz_q;
        rt_d    = rt_q;
        a_d     = a_q;
        b_d     = b_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    ox_d    = bus.p_x;
                    oy_d    = bus.p_y;
                    oz_d    = bus.p_z;
                    ot_d    = bus.p_t;
                    a_d     = bus.p_x;
                    b_d     = bus.p_t;
                    state_d = S_XT;
                end
            end
            S_XT: begin
                start   = 1'b1;
                state_d = W_XT;
            end
            W_XT: begin
                if (bus.mul_done) begin
                    rx_d    = bus.mul_out;
                    a_d     = oy_q;
                    b_d     = oz_q;
                    state_d = S_YZ;
                end
            end
            S_YZ: begin
                start   = 1'b1;
                state_d = W_YZ;
            end
            W_YZ: begin
                if (bus.mul_done) begin
                    ry_d    = bus.mul_out;
                    a_d     = oz_q;
                    b_d     = ot_q;
                    state_d = S_ZT;
                end
            end
            S_ZT: begin
                start   = 1'b1;
                state_d = W_ZT;
            end
            W_ZT: begin
                if (bus.mul_done) begin
                    rz_d    = bus.mul_out;
                    a_d     = ox_q;
                    b_d     = oy_q;
                    state_d = S_XY;
                end
            end
            S_XY: begin
                start   = 1'b1;
                state_d = W_XY;
            end
            W_XY: begin
                if (bus.mul_done) begin
                    rt_d    = bus.mul_out;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.r_x       = rx_q;
    assign bus.r_y       = ry_q;
    assign bus.r_z       = rz_q;
    assign bus.r_t       = rt_q;
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;
    assign bus.mul_start = start;
    assign bus.done      = (state_q == FIN);
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/ge_p1p1_to_p3.md
Name: ge_p1p1_to_p3

Overview:
- Downstream stage of ge_add.
- Converts the completed point (X,Y,Z,T) that ge_add produces on r_x/r_y/r_z/r_t into extended P3 coordinates: X3=X*T, Y3=Y*Z, Z3=Z*T, T3=X*Y.
- Sequences the four field multiplications through one shared external fe_mul over a start/done handshake, then presents the P3 point to the next point-arithmetic stage.
- Owns no arithmetic of its own: operand latching, multiplier scheduling and result capture only.

Parameters:
- FE_W, 320: field-element width; 10 limbs x 32 bits, limb 0 in bits [319:288].

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset).
- valid  input  1  one-cycle pulse; p_* are valid in this cycle.
- p_x  input  FE_W  X of the completed point (from ge_add r_x).
- p_y  input  FE_W  Y of the completed point (from ge_add r_y).
- p_z  input  FE_W  Z of the completed point (from ge_add r_z).
- p_t  input  FE_W  T of the completed point (from ge_add r_t).
- r_x  output  FE_W  X3 = X*T.
- r_y  output  FE_W  Y3 = Y*Z.
- r_z  output  FE_W  Z3 = Z*T.
- r_t  output  FE_W  T3 = X*Y.
- done  output  1  one-cycle pulse; r_* are valid from this cycle on.
- busy  output  1  high from the cycle after valid is accepted until done.
- mul_a  output  FE_W  multiplier operand A.
- mul_b  output  FE_W  multiplier operand B.
- mul_start  output  1  one-cycle multiplier launch.
- mul_done  input  1  one-cycle pulse; mul_out is valid in this cycle.
- mul_out  input  FE_W  multiplier product.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - r_x, r_y, r_z, r_t, mul_a, mul_b and the operand registers clear to 0.
  - done, busy and mul_start go to 0.
  - Reset asserted mid-operation aborts the operation. A mul_done arriving after reset is ignored, and no done is produced.
- States: IDLE, S_XT, W_XT, S_YZ, W_YZ, S_ZT, W_ZT, S_XY, W_XY, FIN.
- IDLE:
  - valid=1 latches p_x/p_y/p_z/p_t into internal registers and moves to S_XT.
  - Otherwise stays in IDLE.
  - mul_done is ignored in IDLE.
- S_* states (one cycle each):
  - mul_start=1 with the operand pairs: S_XT a=X,b=T; S_YZ a=Y,b=Z; S_ZT a=Z,b=T; S_XY a=X,b=Y.
  - Next state is the matching W_* state.
  - A mul_done in the S_* cycle is ignored.
- W_* states:
  - mul_a/mul_b hold their values; mul_start=0.
  - On mul_done=1, mul_out is captured into the target output register (r_x, r_y, r_z, r_t respectively) and the block moves to the next S_* state; W_XY moves to FIN.
  - The wait is unbounded; there is no timeout.
- FIN:
  - done=1 for exactly one cycle, then back to IDLE.
- busy is 1 in every state except IDLE.
- r_* registers update only on their own capture.
  - They hold their last values through IDLE and through the next operation until overwritten.
  - Consumers sample them on done.
- valid while busy=1 or in FIN is ignored. Upstream must wait for done.
- The block never modifies p_* data; the external multiplier is responsible for limb reduction.
- Latency:
  - Multiplier latency L >= 1 cycles (mul_done L cycles after mul_start).
  - valid accepted at cycle 0; first mul_start at cycle 1.
  - Each product takes L+1 cycles; done is asserted at cycle 4(L+1)+1.
- Each mul_start is a single cycle; there is never more than one outstanding multiply.

Test Plan:
- Reset, then idle for 10 cycles with a stub multiplier -> r_* = 0, done = busy = mul_start = 0 throughout.
- Stub fe_mul returns mul_a^mul_b with L=3; valid with p_x=1, p_y=2, p_z=4, p_t=8 -> mul_start at cycles 1, 5, 9, 13; done at cycle 17 only; r_x=9, r_y=6, r_z=C, r_t=3.
- Same stub; valid with p_x=1, p_y=2, p_z=4, p_t=8, then p_* changed and valid re-pulsed at cycle 4 -> second valid ignored; results as in the previous case; busy=1 for cycles 1-17.
- Stub with L=1 and mul_done forced high during every S_* cycle -> spurious pulses ignored; done at cycle 9; results match the XOR model.
- rst=0 at cycle 6 of an L=3 run -> cycle 7: IDLE, r_*=0, busy=0; stale mul_done at cycle 8 ignored; no done; a new valid completes normally.
- Real fe_mul; feed ge_add_tb's expected r outputs (rX=0251...9edd, rY, rZ, rT) -> r_* match the ref10 ge_p1p1_to_p3 golden model; fe_mul operand order per S_* state checked.
